// File: rtl/aes_key_set_loader.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_set_loader
// Purpose  : Stores NUM_SETS round-key sets, streams one set into the AES core
//            on request, and holds user data in a FIFO while keys load.
// Revision : 1.0
// ============================================================================
module aes_key_set_loader #(
    parameter int  NUM_ROUNDS = 10,
    parameter int  NUM_SETS   = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int NUM_KEYS   = NUM_ROUNDS + 1,
    localparam int c_set_w    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int c_idx_w    = $clog2(NUM_KEYS)
) (
    input  logic               clk,
    input  logic               kill,
    input  logic               cfg_wr_en,
    input  logic [c_set_w-1:0] cfg_set,
    input  logic [c_idx_w-1:0] cfg_key_idx,
    input  logic [127:0]       cfg_key,
    input  logic               load_req,
    input  logic [c_set_w-1:0] load_set,
    output logic               busy,
    output logic               load_done,
    output logic               err_pulse,
    input  logic               s_in_en,
    input  logic [127:0]       s_in_data,
    output logic               en_wr,
    output logic [127:0]       key_round_wr,
    output logic               in_en,
    output logic [127:0]       in_data,
    output logic               fifo_overflow
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    typedef enum logic [0:0] {IDLE = 1'b0, LOAD = 1'b1} state_t;

    state_t             r_state, w_state_nxt;
    logic [127:0]       r_keys [NUM_SETS][NUM_KEYS];
    logic [c_set_w-1:0] r_set, w_set_nxt;
    logic [c_idx_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_en_wr, w_en_wr_nxt;
    logic               r_done, w_done_nxt;
    logic               r_err, w_err_nxt;
    logic [127:0]       r_key, w_key_nxt;

    logic w_load_set_ok, w_cfg_set_ok, w_cfg_idx_ok, w_cfg_hits_active;
    logic w_cfg_write, w_cfg_err, w_accept, w_load_err;

    // Compare one bit wider so the range check stays meaningful when the
    // set count fills the whole index space.
    assign w_load_set_ok     = {1'b0, load_set} < (c_set_w + 1)'(NUM_SETS);
    assign w_cfg_set_ok      = {1'b0, cfg_set} < (c_set_w + 1)'(NUM_SETS);
    assign w_cfg_idx_ok      = {1'b0, cfg_key_idx} < (c_idx_w + 1)'(NUM_KEYS);
    assign w_cfg_hits_active = r_busy && (cfg_set == r_set);
    assign w_cfg_write       = cfg_wr_en && w_cfg_set_ok && w_cfg_idx_ok && !w_cfg_hits_active;
    assign w_cfg_err         = cfg_wr_en && !w_cfg_write;
    assign w_accept          = load_req && (r_state == IDLE) && !r_busy && w_load_set_ok;
    assign w_load_err        = load_req && !w_accept;

    always_ff @(posedge clk) begin
        if (w_cfg_write) begin
            r_keys[cfg_set][cfg_key_idx] <= cfg_key;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_set_nxt   = r_set;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = 1'b0;
        w_en_wr_nxt = 1'b0;
        w_key_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = w_cfg_err || w_load_err;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = LOAD;
                    w_set_nxt   = load_set;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_en_wr_nxt = 1'b1;
                    w_key_nxt   = r_keys[load_set][0];
                end
            end
            LOAD: begin
                // busy stays high one extra cycle to cover the load_done beat
                w_busy_nxt = 1'b1;
                if (r_cnt == c_idx_w'(NUM_KEYS - 1)) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_en_wr_nxt = 1'b1;
                    w_key_nxt   = r_keys[r_set][w_cnt_nxt];
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            r_state <= IDLE;
            r_set   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_en_wr <= 1'b0;
            r_key   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_set   <= w_set_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_en_wr <= w_en_wr_nxt;
            r_key   <= w_key_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    logic [127:0]       r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               r_in_en, r_ovf;
    logic [127:0]       r_in_data;
    logic w_can_pop, w_empty, w_full, w_pop, w_bypass, w_push, w_drop;

    // No pop in the acceptance cycle, otherwise a word would land on the
    // core together with the first round key.
    assign w_can_pop = !r_busy && !w_accept;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (c_ptr_w + 1)'(FIFO_DEPTH));
    assign w_pop     = w_can_pop && !w_empty;
    assign w_bypass  = w_can_pop && w_empty && s_in_en;
    assign w_push    = s_in_en && !w_bypass && (!w_full || w_pop);
    assign w_drop    = s_in_en && !w_bypass && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (kill) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_in_en   <= 1'b0;
            r_in_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_in_en   <= w_pop || w_bypass;
            r_in_data <= w_pop ? r_mem[r_rd_ptr] : (w_bypass ? s_in_data : '0);
            r_ovf     <= w_drop;
        end
    end

    assign busy          = r_busy;
    assign load_done     = r_done;
    assign err_pulse     = r_err;
    assign en_wr         = r_en_wr;
    assign key_round_wr  = r_key;
    assign in_en         = r_in_en;
    assign in_data       = r_in_data;
    assign fifo_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_set_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_set_loader
// Purpose  : Scoreboard bench for aes_key_set_loader key streaming and FIFO.
// Revision : 1.0
// ============================================================================
module tb_aes_key_set_loader;
    logic         clk = 1'b0;
    logic         kill = 1'b1;
    logic         cfg_wr_en = 1'b0;
    logic [1:0]   cfg_set = '0;
    logic [3:0]   cfg_key_idx = '0;
    logic [127:0] cfg_key = '0;
    logic         load_req = 1'b0;
    logic [1:0]   load_set = '0;
    logic         s_in_en = 1'b0;
    logic [127:0] s_in_data = '0;
    logic         busy, load_done, err_pulse, en_wr, in_en, fifo_overflow;
    logic [127:0] key_round_wr, in_data;

    logic         load_req3 = 1'b0;
    logic [1:0]   load_set3 = '0;
    logic         busy3, done3, err3, en_wr3, in_en3, ovf3;
    logic [127:0] key3, in_data3;

    int           n_checks = 0;
    int           n_errors = 0;
    logic         mon_on = 1'b0;
    logic [127:0] model [4][11];
    logic [127:0] exp_keys [$];
    logic [127:0] exp_data [$];
    logic [127:0] exp_k, exp_d;

    always #5 clk = ~clk;

    aes_key_set_loader #(.NUM_ROUNDS(10), .NUM_SETS(4), .FIFO_DEPTH(8)) u_dut (
        .clk(clk), .kill(kill), .cfg_wr_en(cfg_wr_en), .cfg_set(cfg_set),
        .cfg_key_idx(cfg_key_idx), .cfg_key(cfg_key), .load_req(load_req),
        .load_set(load_set), .busy(busy), .load_done(load_done), .err_pulse(err_pulse),
        .s_in_en(s_in_en), .s_in_data(s_in_data), .en_wr(en_wr),
        .key_round_wr(key_round_wr), .in_en(in_en), .in_data(in_data),
        .fifo_overflow(fifo_overflow)
    );

    // Three-set instance: lets an out-of-range load_set be expressed.
    aes_key_set_loader #(.NUM_ROUNDS(10), .NUM_SETS(3), .FIFO_DEPTH(8)) u_dut3 (
        .clk(clk), .kill(kill), .cfg_wr_en(1'b0), .cfg_set(2'd0),
        .cfg_key_idx(4'd0), .cfg_key(128'd0), .load_req(load_req3),
        .load_set(load_set3), .busy(busy3), .load_done(done3), .err_pulse(err3),
        .s_in_en(1'b0), .s_in_data(128'd0), .en_wr(en_wr3),
        .key_round_wr(key3), .in_en(in_en3), .in_data(in_data3),
        .fifo_overflow(ovf3)
    );

    always @(negedge clk) begin
        if (mon_on) begin
            n_checks++;
            if (en_wr) begin
                if (exp_keys.size() == 0) begin
                    n_errors++;
                    $display("FAIL key_stream: unexpected en_wr got key %h want none", key_round_wr);
                end else begin
                    exp_k = exp_keys.pop_front();
                    if (key_round_wr !== exp_k) begin
                        n_errors++;
                        $display("FAIL key_stream: got %h want %h", key_round_wr, exp_k);
                    end
                end
            end else if (key_round_wr !== '0) begin
                n_errors++;
                $display("FAIL key_idle_zero: got %h want 0", key_round_wr);
            end
            n_checks++;
            if (in_en) begin
                if (exp_data.size() == 0) begin
                    n_errors++;
                    $display("FAIL data_stream: unexpected in_en got %h want none", in_data);
                end else begin
                    exp_d = exp_data.pop_front();
                    if (in_data !== exp_d) begin
                        n_errors++;
                        $display("FAIL data_stream: got %h want %h", in_data, exp_d);
                    end
                end
            end else if (in_data !== '0) begin
                n_errors++;
                $display("FAIL data_idle_zero: got %h want 0", in_data);
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int s, input int k, input logic [127:0] key);
        cfg_wr_en   = 1'b1;
        cfg_set     = 2'(s);
        cfg_key_idx = 4'(k);
        cfg_key     = key;
        model[s][k] = key;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic load_start(input int s);
        load_req = 1'b1;
        load_set = 2'(s);
        for (int k = 0; k < 11; k++) exp_keys.push_back(model[s][k]);
        tick();
        load_req = 1'b0;
    endtask

    task automatic test_reset();
        kill = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if ({en_wr, in_en, busy, load_done, err_pulse, fifo_overflow, key_round_wr, in_data} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got en_wr=%b in_en=%b busy=%b done=%b err=%b ovf=%b want all 0",
                     en_wr, in_en, busy, load_done, err_pulse, fifo_overflow);
        end
        tick();
        kill = 1'b0;
    endtask

    task automatic test_full_load();
        logic [127:0] key;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 11; k++) begin
                if (s == 1 && k == 0)       key = 128'h0f0e0d0c0b0a09080706050403020100;
                else if (s == 1 && k == 10) key = 128'hc5302b4d8ba707f3174a94e37f1d1113;
                else                        key = rand128();
                cfg_write(s, k, key);
            end
        end
        load_start(1);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            n_checks++;
            if (en_wr !== (i <= 11)) begin
                n_errors++;
                $display("FAIL full_load_en_wr c%0d: got %b want %b", i, en_wr, i <= 11);
            end
            n_checks++;
            if (busy !== (i <= 12)) begin
                n_errors++;
                $display("FAIL full_load_busy c%0d: got %b want %b", i, busy, i <= 12);
            end
            n_checks++;
            if (load_done !== (i == 12)) begin
                n_errors++;
                $display("FAIL full_load_done c%0d: got %b want %b", i, load_done, i == 12);
            end
            tick();
        end
    endtask

    task automatic test_passthrough();
        logic [127:0] word;
        word = 128'hffeeddccbbaa99887766554433221100;
        for (int i = 1; i <= 3; i++) begin
            s_in_en   = (i == 1);
            s_in_data = word;
            if (i == 1) exp_data.push_back(word);
            @(negedge clk);
            n_checks++;
            if (in_en !== (i == 2)) begin
                n_errors++;
                $display("FAIL passthrough_in_en c%0d: got %b want %b", i, in_en, i == 2);
            end
            if (i == 2) begin
                n_checks++;
                if (in_data !== word) begin
                    n_errors++;
                    $display("FAIL passthrough_data: got %h want %h", in_data, word);
                end
            end
            tick();
        end
        s_in_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 8; i++) begin
            s_in_en   = (i <= 5);
            s_in_data = rand128();
            if (s_in_en) exp_data.push_back(s_in_data);
            @(negedge clk);
            n_checks++;
            if (in_en !== (i >= 2 && i <= 6)) begin
                n_errors++;
                $display("FAIL back_to_back_in_en c%0d: got %b want %b", i, in_en, i >= 2 && i <= 6);
            end
            tick();
        end
        s_in_en = 1'b0;
    endtask

    task automatic test_data_hold();
        load_start(2);
        for (int i = 1; i <= 20; i++) begin
            s_in_en   = (i >= 2 && i <= 4);
            s_in_data = rand128();
            if (s_in_en) exp_data.push_back(s_in_data);
            @(negedge clk);
            n_checks++;
            if (in_en !== (i >= 14 && i <= 16)) begin
                n_errors++;
                $display("FAIL hold_in_en c%0d: got %b want %b busy=%b", i, in_en, i >= 14 && i <= 16, busy);
            end
            n_checks++;
            if (busy !== (i <= 12)) begin
                n_errors++;
                $display("FAIL hold_busy c%0d: got %b want %b", i, busy, i <= 12);
            end
            tick();
        end
        s_in_en = 1'b0;
    endtask

    task automatic test_overflow();
        load_start(3);
        for (int i = 1; i <= 27; i++) begin
            s_in_en   = (i <= 9) || (i >= 13 && i <= 15);
            s_in_data = rand128();
            if (s_in_en && i != 9) exp_data.push_back(s_in_data);
            @(negedge clk);
            n_checks++;
            if (fifo_overflow !== (i == 10)) begin
                n_errors++;
                $display("FAIL overflow_pulse c%0d: got %b want %b", i, fifo_overflow, i == 10);
            end
            n_checks++;
            if (in_en !== (i >= 14 && i <= 24)) begin
                n_errors++;
                $display("FAIL overflow_in_en c%0d: got %b want %b", i, in_en, i >= 14 && i <= 24);
            end
            tick();
        end
        s_in_en = 1'b0;
    endtask

    task automatic test_errors();
        load_start(1);
        for (int i = 1; i <= 14; i++) begin
            load_req    = (i == 2);
            load_set    = 2'd0;
            cfg_wr_en   = (i == 4 || i == 6);
            cfg_set     = (i == 4) ? 2'd1 : 2'd0;
            cfg_key_idx = (i == 4) ? 4'd3 : 4'd2;
            cfg_key     = rand128();
            if (i == 6) model[0][2] = cfg_key;
            @(negedge clk);
            n_checks++;
            if (err_pulse !== (i == 3 || i == 5)) begin
                n_errors++;
                $display("FAIL err_during_load c%0d: got %b want %b", i, err_pulse, i == 3 || i == 5);
            end
            n_checks++;
            if (en_wr !== (i <= 11) || load_done !== (i == 12)) begin
                n_errors++;
                $display("FAIL err_load_timing c%0d: got en_wr=%b done=%b want %b/%b",
                         i, en_wr, load_done, i <= 11, i == 12);
            end
            tick();
        end
        cfg_wr_en   = 1'b1;
        cfg_set     = 2'd0;
        cfg_key_idx = 4'd11;
        cfg_key     = rand128();
        tick();
        cfg_wr_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_pulse !== 1'b1) begin
            n_errors++;
            $display("FAIL err_bad_idx: got %b want 1", err_pulse);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (err_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL err_single_cycle: got %b want 0", err_pulse);
        end
        tick();
    endtask

    task automatic test_bad_set();
        load_req3 = 1'b1;
        load_set3 = 2'd3;
        tick();
        load_req3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err3 !== 1'b1 || busy3 !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_set_reject: got err=%b busy=%b want 1/0", err3, busy3);
        end
        tick();
        load_req3 = 1'b1;
        load_set3 = 2'd2;
        tick();
        load_req3 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err3 !== 1'b0 || busy3 !== 1'b1) begin
            n_errors++;
            $display("FAIL last_set_accept: got err=%b busy=%b want 0/1", err3, busy3);
        end
        for (int i = 0; i < 14; i++) tick();
    endtask

    task automatic test_kill_midload();
        load_start(1);
        for (int i = 1; i <= 20; i++) begin
            kill      = (i == 6 || i == 7);
            s_in_en   = (i == 2 || i == 3);
            s_in_data = rand128();
            if (i == 8) begin
                n_checks++;
                if (exp_keys.size() !== 5) begin
                    n_errors++;
                    $display("FAIL kill_keys_seen: got %0d left want 5", exp_keys.size());
                end
                exp_keys.delete();
            end
            @(negedge clk);
            n_checks++;
            if (en_wr !== (i <= 6)) begin
                n_errors++;
                $display("FAIL kill_en_wr c%0d: got %b want %b", i, en_wr, i <= 6);
            end
            if (i >= 7) begin
                n_checks++;
                if (busy !== 1'b0 || load_done !== 1'b0 || in_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL kill_after c%0d: got busy=%b done=%b in_en=%b want 0/0/0",
                             i, busy, load_done, in_en);
                end
            end
            if (i == 7) begin
                n_checks++;
                if ({key_round_wr, in_data, err_pulse, fifo_overflow} !== '0) begin
                    n_errors++;
                    $display("FAIL kill_outputs: got key=%h err=%b ovf=%b want 0", key_round_wr, err_pulse, fifo_overflow);
                end
            end
            tick();
        end
        s_in_en = 1'b0;
        load_start(1);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            n_checks++;
            if (en_wr !== (i <= 11) || load_done !== (i == 12)) begin
                n_errors++;
                $display("FAIL reload c%0d: got en_wr=%b done=%b want %b/%b", i, en_wr, load_done, i <= 11, i == 12);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        mon_on = 1'b1;
        test_full_load();
        test_passthrough();
        test_back_to_back();
        test_data_hold();
        test_overflow();
        test_errors();
        test_bad_set();
        test_kill_midload();
        tick();
        n_checks++;
        if (exp_keys.size() !== 0) begin
            n_errors++;
            $display("FAIL keys_left: got %0d want 0", exp_keys.size());
        end
        n_checks++;
        if (exp_data.size() !== 0) begin
            n_errors++;
            $display("FAIL data_left: got %0d want 0", exp_data.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
